// File: rtl/stream_dispatcher.sv
// Routes each whole packet of one input stream to one of REQS output lanes,
// chosen at head time among ready lanes, through a single registered stage.
module stream_dispatcher #(
    parameter int    REQS   = 4,
    parameter int    WIDTH  = 8,
    parameter string SCHEME = "RR"
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        i_dat,
    input  logic                    i_eop,
    input  logic                    i_val,
    output logic                    i_rdy,
    output logic [WIDTH-1:0]        o_dat,
    output logic                    o_eop,
    output logic [REQS-1:0]         o_val,
    input  logic [REQS-1:0]         o_rdy,
    output logic [$clog2(REQS)-1:0] num
);

    localparam int NW = $clog2(REQS);
    localparam bit FP = (SCHEME == "FP");

    localparam logic [0:0] HEAD = 1'b0;
    localparam logic [0:0] BODY = 1'b1;

    logic [0:0]       state;
    logic             full;
    logic [WIDTH-1:0] dat;
    logic             eop;
    logic [NW-1:0]    dst;
    logic [NW-1:0]    lck;
    logic [NW-1:0]    ptr;
    logic [NW-1:0]    cand;
    logic [NW-1:0]    nxt;
    logic             hit;
    logic             head;
    logic             sp;
    logic             load;
    logic             drain;

    // first ready lane at or after the search base, wrapping around
    always_comb begin
        int base;
        int k;
        base = FP ? 0 : int'(ptr);
        k    = 0;
        cand = '0;
        hit  = 1'b0;
        for (int i = 0; i < REQS; i++) begin
            k = (base + i) % REQS;
            if (!hit && o_rdy[NW'(k)]) begin
                cand = NW'(k);
                hit  = 1'b1;
            end
        end
    end

    assign nxt   = NW'((int'(cand) + 1) % REQS);
    assign head  = (state == HEAD);
    assign drain = full & o_rdy[dst];
    assign sp    = ~full | o_rdy[dst];
    assign i_rdy = ~reset & sp & (~head | (|o_rdy));
    assign load  = i_val & i_rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= HEAD;
            full  <= 1'b0;
            dat   <= '0;
            eop   <= 1'b0;
            dst   <= '0;
            lck   <= '0;
            ptr   <= '0;
        end else begin
            if (load) begin
                full <= 1'b1;
                dat  <= i_dat;
                eop  <= i_eop;
                dst  <= head ? cand : lck;
            end else if (drain) begin
                full <= 1'b0;
            end

            if (load && head) begin
                ptr <= FP ? ptr : nxt;
                if (!i_eop) begin
                    state <= BODY;
                    lck   <= cand;
                end
            end else if (load && i_eop) begin
                state <= HEAD;
            end
        end
    end

    assign o_val = full ? (REQS'(1) << dst) : '0;
    assign o_dat = dat;
    assign o_eop = eop;
    assign num   = dst;

endmodule

// File: tb/tb_stream_dispatcher.sv
// Bench for stream_dispatcher: RR and FP instances share one input stream
// and are checked against a packet-level reference model every cycle.
module tb_stream_dispatcher;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] i_dat;
    logic       i_eop;
    logic       i_val;
    logic [3:0] o_rdy;

    logic       ir [2];
    logic [7:0] od [2];
    logic       oe [2];
    logic [3:0] ov [2];
    logic [1:0] nm [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stream_dispatcher #(.REQS(4), .WIDTH(8), .SCHEME("RR")) u_rr (
        .clk(clk), .reset(reset),
        .i_dat(i_dat), .i_eop(i_eop), .i_val(i_val), .i_rdy(ir[0]),
        .o_dat(od[0]), .o_eop(oe[0]), .o_val(ov[0]), .o_rdy(o_rdy),
        .num(nm[0])
    );

    stream_dispatcher #(.REQS(4), .WIDTH(8), .SCHEME("FP")) u_fp (
        .clk(clk), .reset(reset),
        .i_dat(i_dat), .i_eop(i_eop), .i_val(i_val), .i_rdy(ir[1]),
        .o_dat(od[1]), .o_eop(oe[1]), .o_val(ov[1]), .o_rdy(o_rdy),
        .num(nm[1])
    );

    // reference: packet in progress flag, held entry, lane lock, rr pointer
    typedef struct {
        bit         body;
        bit         full;
        logic [7:0] dat;
        bit         eop;
        int         dst;
        int         lck;
        int         ptr;
    } mdl_t;

    mdl_t m [2];

    typedef struct {
        logic [3:0] rdy;
        logic       val;
        logic       eop;
        logic [7:0] dat;
        logic       e_irdy;
        logic [3:0] e_oval;
        logic [1:0] e_num;
        logic [7:0] e_dat;
        logic       e_eop;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(logic [3:0] r, logic v, logic e, logic [7:0] d,
                                logic xi, logic [3:0] xv, logic [1:0] xn,
                                logic [7:0] xd, logic xe);
        vec_t t;
        t.rdy = r; t.val = v; t.eop = e; t.dat = d;
        t.e_irdy = xi; t.e_oval = xv; t.e_num = xn;
        t.e_dat = xd; t.e_eop = xe;
        return t;
    endfunction

    function automatic bit rdy(int d);
        logic [1:0] di;
        di = 2'(d);
        return o_rdy[di];
    endfunction

    function automatic int pick(int r);
        int base;
        base = (r == 0) ? m[r].ptr : 0;
        for (int i = 0; i < 4; i++)
            if (rdy((base + i) % 4)) return (base + i) % 4;
        return -1;
    endfunction

    function automatic bit exp_irdy(int r);
        bit sp;
        if (reset) return 1'b0;
        sp = !m[r].full || rdy(m[r].dst);
        if (m[r].body) return sp;
        return sp && (o_rdy != 4'b0);
    endfunction

    task automatic mreset();
        for (int r = 0; r < 2; r++) begin
            m[r].body = 0; m[r].full = 0; m[r].dat = 8'h00;
            m[r].eop = 0; m[r].dst = 0; m[r].lck = 0; m[r].ptr = 0;
        end
    endtask

    task automatic mupdate();
        for (int r = 0; r < 2; r++) begin
            bit ld;
            int c;
            ld = i_val && exp_irdy(r);
            c  = pick(r);
            if (reset) begin
                m[r].body = 0; m[r].full = 0; m[r].dat = 8'h00;
                m[r].eop = 0; m[r].dst = 0; m[r].lck = 0; m[r].ptr = 0;
            end else if (ld) begin
                m[r].full = 1;
                m[r].dat  = i_dat;
                m[r].eop  = i_eop;
                if (m[r].body) begin
                    m[r].dst = m[r].lck;
                    if (i_eop) m[r].body = 0;
                end else begin
                    m[r].dst = c;
                    if (r == 0) m[r].ptr = (c + 1) % 4;
                    if (!i_eop) begin
                        m[r].body = 1;
                        m[r].lck  = c;
                    end
                end
            end else if (m[r].full && rdy(m[r].dst)) begin
                m[r].full = 0;
            end
        end
    endtask

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    task automatic mcheck();
        for (int r = 0; r < 2; r++) begin
            string p;
            p = (r == 0) ? "rr" : "fp";
            chk({p, " o_val"}, 32'(ov[r]),
                m[r].full ? (32'd1 << m[r].dst) : 32'd0);
            chk({p, " num"}, 32'(nm[r]), 32'(m[r].dst));
            chk({p, " i_rdy"}, 32'(ir[r]), 32'(exp_irdy(r)));
            chk({p, " o_dat"}, 32'(od[r]), 32'(m[r].dat));
            chk({p, " o_eop"}, 32'(oe[r]), 32'(m[r].eop));
        end
    endtask

    task automatic tick();
        #1;
        mcheck();
        @(posedge clk);
        mupdate();
        #1;
    endtask

    task automatic drive(logic [3:0] r, logic v, logic e, logic [7:0] d);
        o_rdy = r; i_val = v; i_eop = e; i_dat = d;
    endtask

    task automatic set_reset(bit v);
        reset = v;
        if (v) mreset();
    endtask

    initial begin
        // four 3-word packets, all lanes ready
        tbl[0]  = mk(4'hF, 1, 0, 8'd1,  1, 4'h0, 2'd0, 8'd0,  0);
        tbl[1]  = mk(4'hF, 1, 0, 8'd2,  1, 4'h1, 2'd0, 8'd1,  0);
        tbl[2]  = mk(4'hF, 1, 1, 8'd3,  1, 4'h1, 2'd0, 8'd2,  0);
        tbl[3]  = mk(4'hF, 1, 0, 8'd4,  1, 4'h1, 2'd0, 8'd3,  1);
        tbl[4]  = mk(4'hF, 1, 0, 8'd5,  1, 4'h2, 2'd1, 8'd4,  0);
        tbl[5]  = mk(4'hF, 1, 1, 8'd6,  1, 4'h2, 2'd1, 8'd5,  0);
        tbl[6]  = mk(4'hF, 1, 0, 8'd7,  1, 4'h2, 2'd1, 8'd6,  1);
        tbl[7]  = mk(4'hF, 1, 0, 8'd8,  1, 4'h4, 2'd2, 8'd7,  0);
        tbl[8]  = mk(4'hF, 1, 1, 8'd9,  1, 4'h4, 2'd2, 8'd8,  0);
        tbl[9]  = mk(4'hF, 1, 0, 8'd10, 1, 4'h4, 2'd2, 8'd9,  1);
        tbl[10] = mk(4'hF, 1, 0, 8'd11, 1, 4'h8, 2'd3, 8'd10, 0);
        tbl[11] = mk(4'hF, 1, 1, 8'd12, 1, 4'h8, 2'd3, 8'd11, 0);
        tbl[12] = mk(4'hF, 0, 0, 8'd0,  1, 4'h8, 2'd3, 8'd12, 1);
        tbl[13] = mk(4'hF, 0, 0, 8'd0,  1, 4'h0, 2'd3, 8'd0,  0);

        set_reset(1);
        drive(4'hF, 1, 0, 8'h55);
        #1;
        for (int r = 0; r < 2; r++) begin
            chk("rst o_val", 32'(ov[r]), 32'd0);
            chk("rst i_rdy", 32'(ir[r]), 32'd0);
            chk("rst num", 32'(nm[r]), 32'd0);
            chk("rst o_dat", 32'(od[r]), 32'd0);
        end
        tick();
        tick();
        set_reset(0);

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].rdy, tbl[i].val, tbl[i].eop, tbl[i].dat);
            #1;
            chk($sformatf("tbl%0d i_rdy", i), 32'(ir[0]), 32'(tbl[i].e_irdy));
            chk($sformatf("tbl%0d o_val", i), 32'(ov[0]), 32'(tbl[i].e_oval));
            chk($sformatf("tbl%0d num", i), 32'(nm[0]), 32'(tbl[i].e_num));
            if (tbl[i].e_oval != 4'h0) begin
                chk($sformatf("tbl%0d o_dat", i), 32'(od[0]), 32'(tbl[i].e_dat));
                chk($sformatf("tbl%0d o_eop", i), 32'(oe[0]), 32'(tbl[i].e_eop));
            end
            tick();
        end

        // rr pointer walks to 3, then wraps to lane 0 with only lane 0 ready
        drive(4'hF, 1, 1, 8'hA0); tick();
        drive(4'hF, 1, 1, 8'hA1); tick();
        drive(4'hF, 1, 1, 8'hA2); tick();
        drive(4'hF, 0, 0, 8'h00); tick();
        drive(4'h1, 1, 1, 8'hA3);
        #1;
        chk("wrap i_rdy", 32'(ir[0]), 32'd1);
        tick();
        drive(4'h0, 0, 0, 8'h00);
        #1;
        chk("wrap o_val", 32'(ov[0]), 32'h1);
        chk("wrap num", 32'(nm[0]), 32'd0);
        chk("wrap o_dat", 32'(od[0]), 32'hA3);
        tick();
        drive(4'hF, 1, 1, 8'hA4);
        #1;
        chk("ptr1 i_rdy", 32'(ir[0]), 32'd1);
        tick();
        drive(4'hF, 0, 0, 8'h00);
        #1;
        chk("ptr1 o_val", 32'(ov[0]), 32'h2);
        chk("ptr1 num", 32'(nm[0]), 32'd1);
        tick();

        // fixed priority with lanes 1,2 ready
        drive(4'h6, 1, 0, 8'hB0); tick();
        drive(4'h6, 1, 1, 8'hB1);
        #1;
        chk("fp b0 o_val", 32'(ov[1]), 32'h2);
        chk("fp b0 o_dat", 32'(od[1]), 32'hB0);
        tick();
        drive(4'h6, 1, 0, 8'hB2);
        #1;
        chk("fp b1 o_val", 32'(ov[1]), 32'h2);
        chk("fp b1 o_eop", 32'(oe[1]), 32'd1);
        tick();
        drive(4'h6, 1, 1, 8'hB3); tick();
        drive(4'h0, 1, 0, 8'hB4);
        #1;
        chk("fp none i_rdy", 32'(ir[1]), 32'd0);
        chk("rr none i_rdy", 32'(ir[0]), 32'd0);
        chk("fp b3 o_dat", 32'(od[1]), 32'hB3);
        tick();
        #1;
        chk("fp hold o_val", 32'(ov[1]), 32'h2);
        chk("fp hold o_dat", 32'(od[1]), 32'hB3);
        drive(4'hF, 0, 0, 8'h00); tick();

        // packet locked to lane 2, lane 2 stalls while others are ready
        drive(4'hF, 1, 0, 8'hC0); tick();
        drive(4'hB, 1, 0, 8'hC1);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall o_val", 32'(ov[0]), 32'h4);
            chk("stall o_dat", 32'(od[0]), 32'hC0);
            chk("stall i_rdy", 32'(ir[0]), 32'd0);
            tick();
        end
        drive(4'hF, 1, 1, 8'hC1);
        #1;
        chk("resume i_rdy", 32'(ir[0]), 32'd1);
        tick();
        drive(4'hF, 0, 0, 8'h00);
        #1;
        chk("resume o_val", 32'(ov[0]), 32'h4);
        chk("resume o_dat", 32'(od[0]), 32'hC1);
        tick();

        // reset in the middle of a packet with the entry full
        drive(4'h6, 1, 0, 8'hD0); tick();
        #2;
        set_reset(1);
        #1;
        chk("async rr o_val", 32'(ov[0]), 32'd0);
        chk("async fp o_val", 32'(ov[1]), 32'd0);
        chk("async i_rdy", 32'(ir[0]), 32'd0);
        tick();
        set_reset(0);
        drive(4'hF, 1, 1, 8'hE0); tick();
        drive(4'h0, 0, 0, 8'h00);
        #1;
        chk("post rst rr o_val", 32'(ov[0]), 32'h1);
        chk("post rst fp o_val", 32'(ov[1]), 32'h1);
        chk("post rst o_dat", 32'(od[0]), 32'hE0);
        tick();

        for (int n = 0; n < 2500; n++) begin
            logic [3:0] rr;
            rr = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            set_reset($urandom_range(0, 299) == 0);
            drive(rr, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  8'($urandom));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
